// File: rtl/fifo_pkg.sv
// Shared defaults and sizing helpers for the synchronous threshold FIFO.
package fifo_pkg;

    localparam int DEF_DATA_SIZE = 8;
    localparam int DEF_MAIN_SIZE = 4;

    // Occupancy needs one extra bit so that a completely full FIFO (DEPTH) is representable.
    function automatic int occ_width(input int main_size);
        return main_size + 1;
    endfunction

endpackage

// File: rtl/fifo_mem_dp.sv
// DEPTH x DATA_SIZE storage: one synchronous write port, one synchronous read port, no reset.
module fifo_mem_dp
    import fifo_pkg::*;
#(
    parameter int DATA_SIZE = DEF_DATA_SIZE,
    parameter int MAIN_SIZE = DEF_MAIN_SIZE
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [MAIN_SIZE-1:0] wr_addr,
    input  logic [DATA_SIZE-1:0] wr_data,
    input  logic                 rd_en,
    input  logic [MAIN_SIZE-1:0] rd_addr,
    output logic [DATA_SIZE-1:0] rd_data
);

    localparam int DEPTH = 2 ** MAIN_SIZE;

    logic [DATA_SIZE-1:0] mem [DEPTH];

    // Read returns the old contents when both ports hit the same address.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fifo_sync_thresh.sv
// Synchronous FIFO with internal pointers, occupancy count, programmable
// almost-full/almost-empty thresholds and one-cycle overflow/underflow pulses.
module fifo_sync_thresh
    import fifo_pkg::*;
#(
    parameter int DATA_SIZE = DEF_DATA_SIZE,
    parameter int MAIN_SIZE = DEF_MAIN_SIZE
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              write,
    input  logic                              read,
    input  logic [DATA_SIZE-1:0]              data_in,
    input  logic [occ_width(MAIN_SIZE)-1:0]   af_th,
    input  logic [occ_width(MAIN_SIZE)-1:0]   ae_th,
    output logic [DATA_SIZE-1:0]              data_out,
    output logic                              valid_out,
    output logic [occ_width(MAIN_SIZE)-1:0]   fifo_count,
    output logic                              full,
    output logic                              empty,
    output logic                              almost_full,
    output logic                              almost_empty,
    output logic                              overflow_err,
    output logic                              underflow_err
);

    localparam int CW    = occ_width(MAIN_SIZE);
    localparam int DEPTH = 2 ** MAIN_SIZE;
    localparam logic [CW-1:0]        DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0]        CNT_ONE = CW'(1);
    localparam logic [MAIN_SIZE-1:0] PTR_ONE = MAIN_SIZE'(1);

    // Handshake: write/read are requests sampled on each rising edge. A push is
    // accepted when not full or when a pop is accepted on the same edge; a pop is
    // accepted when not empty. valid_out is high for exactly the cycle after an
    // accepted pop and qualifies data_out; rejected requests raise an error pulse.

    logic [MAIN_SIZE-1:0] wr_ptr;
    logic [MAIN_SIZE-1:0] rd_ptr;
    logic [CW-1:0]        count_q;
    logic [DATA_SIZE-1:0] rd_data;
    logic                 out_zero;
    logic                 push_acc;
    logic                 pop_acc;

    assign full         = (count_q == DEPTH_C);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= af_th);
    assign almost_empty = (count_q <= ae_th);
    assign fifo_count   = count_q;

    assign pop_acc  = read && !empty;
    assign push_acc = write && (!full || pop_acc);

    fifo_mem_dp #(
        .DATA_SIZE (DATA_SIZE),
        .MAIN_SIZE (MAIN_SIZE)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push_acc),
        .wr_addr (wr_ptr),
        .wr_data (data_in),
        .rd_en   (pop_acc),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    // The storage has no reset, so data_out reads as zero until the first pop after reset.
    assign data_out = out_zero ? '0 : rd_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count_q       <= '0;
            valid_out     <= 1'b0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
            out_zero      <= 1'b1;
        end else begin
            if (push_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_acc) begin
                rd_ptr   <= rd_ptr + PTR_ONE;
                out_zero <= 1'b0;
            end
            case ({push_acc, pop_acc})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
            valid_out     <= pop_acc;
            overflow_err  <= write && full && !pop_acc;
            underflow_err <= read && empty;
        end
    end

endmodule
